serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder built around the halfadder primitive. Two half

---
 rtl/serial_adder.sv | 90 +++++++++
 tb/tb_serial_adder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, one bit per clock
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             sum_bit
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             h1;
  logic             c1;
  logic             h2;
  logic             c2;
  logic             last;
  logic [WIDTH-1:0] sum_next;

  // Full adder from two half adders plus an OR on the carries.
  always_comb begin
    h1       = sa[0] ^ sb[0];
    c1       = sa[0] & sb[0];
    h2       = h1 ^ carry;
    c2       = h1 & carry;
    busy     = (state == ADD);
    done     = (state == DONE);
    sum_bit  = busy & h2;
    last     = (cnt == CW'(WIDTH - 1));
    sum_next = {h2, sum_sr};
  end

  // The final bit goes straight into sum so the result is visible in the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sa        <= '0;
      sb        <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= 1'b0;
            cnt   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          carry  <= c1 | c2;
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          sum_sr <= sum_next[WIDTH-1:1];
          cnt    <= cnt + CW'(1);
          if (last) begin
            sum       <= sum_next;
            carry_out <= c1 | c2;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder against an arithmetic model
module tb_serial_adder;

  localparam int W = 8;
  localparam int P = W + 2;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         sum_bit;

  int n_cmp;
  int n_fail;
  logic [W:0] prev_res;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .sum_bit   (sum_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model_add(input logic [W-1:0] x, input logic [W-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // Stimulus helper: launches one add from IDLE and returns what was observed.
  // Returns positioned at the negedge of the cycle following the busy window.
  task automatic run_add(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W:0] prior,
                         output logic [W-1:0] s, output logic c,
                         output logic [W-1:0] bits, output int busy_cnt,
                         output logic done_ok, output logic hold_ok);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bits = '0; busy_cnt = 0; hold_ok = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (busy && !done) busy_cnt++;
      if ({carry_out, sum} !== prior) hold_ok = 1'b0;
      bits[i] = sum_bit;
      @(negedge clk);
    end
    done_ok = done && !busy;
    s = sum;
    c = carry_out;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, sum, carry_out, sum_bit} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h co=%b sb=%b, want all 0",
               busy, done, sum, carry_out, sum_bit);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
    prev_res = '0;
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] s, bits;
    logic c, dok, hok;
    int bc;
    logic [W:0] exp;
    exp = model_add(x, y);
    run_add(x, y, prev_res, s, c, bits, bc, dok, hok);
    n_cmp++;
    if ({c, s} !== exp) begin
      n_fail++;
      $display("FAIL %s_result: got co=%b sum=%h, want co=%b sum=%h", name, c, s, exp[W], exp[W-1:0]);
    end
    n_cmp++;
    if (bits !== exp[W-1:0]) begin
      n_fail++;
      $display("FAIL %s_serial_bits: got %b (lsb first from right), want %b", name, bits, exp[W-1:0]);
    end
    n_cmp++;
    if (bc !== W || dok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timing: got busy_cycles=%0d done_ok=%b, want %0d 1", name, bc, dok, W);
    end
    n_cmp++;
    if (hok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_hold_prior: sum/carry_out changed during add, want %h held", name, prev_res);
    end
    prev_res = exp;
  endtask

  task automatic test_start_ignored();
    @(negedge clk);
    a = 8'h03; b = 8'h04; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (W - 3) @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_done_cycle: got done=%b busy=%b, want 1 0", done, busy);
    end
    n_cmp++;
    if ({carry_out, sum} !== 9'h007) begin
      n_fail++;
      $display("FAIL ignore_result: got co=%b sum=%h, want 0 07", carry_out, sum);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || {carry_out, sum} !== 9'h007) begin
      n_fail++;
      $display("FAIL ignore_start_in_done: got busy=%b done=%b co=%b sum=%h, want 0 0 0 07",
               busy, done, carry_out, sum);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_no_restart: got busy=%b, want 0", busy);
    end
    prev_res = 9'h007;
  endtask

  task automatic test_reset_mid_add();
    logic saw;
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_busy_before: got busy=%b, want 1", busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, sum, carry_out, sum_bit} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%b done=%b sum=%h co=%b sb=%b, want all 0",
               busy, done, sum, carry_out, sum_bit);
    end
    @(negedge clk); rst = 1'b0;
    saw = 1'b0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    n_cmp++;
    if (saw !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_no_done: got activity after reset=%b, want 0", saw);
    end
    prev_res = '0;
    test_directed("rerun_80_80", 8'h80, 8'h80);
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      test_directed("random", W'($urandom), W'($urandom));
    end
  endtask

  task automatic test_back_to_back(input int ops);
    logic [W:0] q[$];
    logic [W:0] exp;
    int n_done;
    int ph;
    n_done = 0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < ops * P; cyc++) begin
      ph = cyc % P;
      a = W'($urandom);
      b = W'($urandom);
      if (ph == 0) q.push_back(model_add(a, b));
      n_cmp++;
      if (busy !== (ph >= 1 && ph <= W) || done !== (ph == P - 1)) begin
        n_fail++;
        $display("FAIL b2b_phase: cycle %0d got busy=%b done=%b, want %b %b",
                 cyc, busy, done, (ph >= 1 && ph <= W), (ph == P - 1));
      end
      if (done) begin
        n_done++;
        exp = (q.size() > 0) ? q.pop_front() : 'x;
        n_cmp++;
        if ({carry_out, sum} !== exp) begin
          n_fail++;
          $display("FAIL b2b_result: op %0d got co=%b sum=%h, want co=%b sum=%h",
                   n_done, carry_out, sum, exp[W], exp[W-1:0]);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (n_done !== ops || q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d done pulses (%0d pending), want %0d", n_done, q.size(), ops);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    prev_res = '0;
    test_reset();
    test_directed("add_0f_01", 8'h0F, 8'h01);
    test_directed("wrap_ff_01", 8'hFF, 8'h01);
    test_directed("nocarry_a5_5a", 8'hA5, 8'h5A);
    test_start_ignored();
    test_reset_mid_add();
    test_random(20);
    test_back_to_back(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
